// File: rtl/ffu_frf_port_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ffu_frf_port_ctl
// Purpose  : Initiator for the FP register file single R/W port. Serialises
//            FFU read/write requests, adds SEC-DED ECC per 32-bit word on
//            writes, and corrects returned read data. Optionally scrubs
//            corrected words back into the register file.
// Revision : 1.0  initial release
// ============================================================================
module ffu_frf_port_ctl #(
  parameter bit SCRUB_EN = 1'b1,
  parameter int RD_LAT   = 2
) (
  input  logic        rclk,
  input  logic        reset,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_wr,
  input  logic [1:0]  req_hmask,
  input  logic [6:0]  req_addr,
  input  logic [63:0] req_data,
  output logic [1:0]  ctl_frf_wen,
  output logic        ctl_frf_ren,
  output logic [6:0]  ctl_frf_addr,
  output logic [77:0] dp_frf_data,
  input  logic [77:0] frf_dp_data,
  output logic        rsp_vld,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_ce,
  output logic [1:0]  rsp_ue
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RW1   = 3'd3,
    S_RW2   = 3'd4,
    S_SCRUB = 3'd5
  } state_t;

  // Check bits for one 32-bit word. Data bits occupy the non-power-of-two
  // codeword positions 3..38 in ascending order; c[6] is overall parity.
  function automatic logic [6:0] ecc_gen(input logic [31:0] d);
    logic [6:0] c;
    logic [4:0] j;
    c = '0;
    j = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        for (int i = 0; i < 6; i++) begin
          if (pos[i]) c[i] = c[i] ^ d[j];
        end
        j = j + 5'd1;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  // One stored word in port layout {ecc[6:0], data[31:0]}.
  function automatic logic [38:0] ecc_enc(input logic [31:0] d);
    return {ecc_gen(d), d};
  endfunction

  // Returns {ue, ce, data}. Uncorrectable words return the raw data bits.
  function automatic logic [33:0] ecc_dec(input logic [38:0] w);
    logic [31:0] d;
    logic [31:0] dout;
    logic [6:0]  c_re;
    logic [5:0]  s;
    logic        p;
    logic        ce;
    logic        ue;
    logic [4:0]  j;
    d    = w[31:0];
    dout = d;
    c_re = ecc_gen(d);
    s    = c_re[5:0] ^ w[37:32];
    p    = ^w;
    ce   = 1'b0;
    ue   = 1'b0;
    j    = '0;
    if (p) begin
      if (s == 6'd0) begin
        ce = 1'b1;                          // overall parity bit itself
      end else if ((s & (s - 6'd1)) == 6'd0) begin
        ce = 1'b1;                          // one of c[5:0]
      end else if (s <= 6'd38) begin
        ce = 1'b1;                          // data bit at position s
        for (int pos = 1; pos <= 38; pos++) begin
          if ((pos & (pos - 1)) != 0) begin
            if (s == 6'(pos)) dout[j] = ~dout[j];
            j = j + 5'd1;
          end
        end
      end else begin
        ue = 1'b1;                          // syndrome beyond the codeword
      end
    end else if (s != 6'd0) begin
      ue = 1'b1;                            // even number of flips
    end
    return {ue, ce, dout};
  endfunction

  state_t      state_q;
  logic [1:0]  hmask_q;
  logic [3:0]  lat_cnt_q;
  logic        req_rdy_q;
  logic [1:0]  wen_q;
  logic        ren_q;
  logic [6:0]  addr_q;
  logic [77:0] wdata_q;
  logic        rsp_vld_q;
  logic [63:0] rsp_data_q;
  logic [1:0]  rsp_ce_q;
  logic [1:0]  rsp_ue_q;

  logic [33:0] w_dec_lo;
  logic [33:0] w_dec_hi;
  logic [31:0] w_cor_lo;
  logic [31:0] w_cor_hi;
  logic [1:0]  w_ce;
  logic [1:0]  w_ue;

  // Decode both returned words; disabled words read as clean zero.
  always_comb begin
    w_dec_lo = ecc_dec(frf_dp_data[38:0]);
    w_dec_hi = ecc_dec(frf_dp_data[77:39]);
    w_cor_lo = hmask_q[0] ? w_dec_lo[31:0] : 32'h0;
    w_cor_hi = hmask_q[1] ? w_dec_hi[31:0] : 32'h0;
    w_ce     = {hmask_q[1] & w_dec_hi[32], hmask_q[0] & w_dec_lo[32]};
    w_ue     = {hmask_q[1] & w_dec_hi[33], hmask_q[0] & w_dec_lo[33]};
  end

  // Port sequencer: state and every port/response output are registered here.
  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hmask_q    <= '0;
      lat_cnt_q  <= '0;
      req_rdy_q  <= 1'b0;
      wen_q      <= '0;
      ren_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_ce_q   <= '0;
      rsp_ue_q   <= '0;
    end else begin
      wen_q     <= '0;
      ren_q     <= 1'b0;
      wdata_q   <= '0;
      rsp_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          req_rdy_q <= 1'b1;
          if (req_vld && req_rdy_q && (req_hmask != 2'b00)) begin
            req_rdy_q <= 1'b0;
            hmask_q   <= req_hmask;
            addr_q    <= req_addr;
            if (req_wr) begin
              state_q <= S_WR;
              wen_q   <= req_hmask;
              wdata_q <= {ecc_enc(req_data[63:32]), ecc_enc(req_data[31:0])};
            end else begin
              state_q   <= S_RD;
              ren_q     <= 1'b1;
              lat_cnt_q <= 4'(RD_LAT - 2);
            end
          end
        end
        S_WR: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b1;
        end
        S_RD: begin
          state_q <= S_RW1;
        end
        S_RW1: begin
          if (lat_cnt_q == 4'd0) state_q <= S_RW2;
          else                   lat_cnt_q <= lat_cnt_q - 4'd1;
        end
        S_RW2: begin
          rsp_vld_q  <= 1'b1;
          rsp_data_q <= {w_cor_hi, w_cor_lo};
          rsp_ce_q   <= w_ce;
          rsp_ue_q   <= w_ue;
          if (SCRUB_EN && (w_ce != 2'b00) && (w_ue == 2'b00)) begin
            state_q <= S_SCRUB;
            wen_q   <= w_ce;
            wdata_q <= {ecc_enc(w_cor_hi), ecc_enc(w_cor_lo)};
          end else begin
            state_q   <= S_IDLE;
            req_rdy_q <= 1'b1;
          end
        end
        S_SCRUB: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          req_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_rdy      = req_rdy_q;
  assign ctl_frf_wen  = wen_q;
  assign ctl_frf_ren  = ren_q;
  assign ctl_frf_addr = addr_q;
  assign dp_frf_data  = wdata_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_ce       = rsp_ce_q;
  assign rsp_ue       = rsp_ue_q;

endmodule
`default_nettype wire
